pulse_stepper: RTL and testbench

PULSE_STEPPER -- requirements
Module: pulse_stepper

---
 rtl/pulse_stepper.sv | 145 ++++++++++++++
 tb/tb_pulse_stepper.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stepper.sv
// -----------------------------------------------------------------------------
// pulse_stepper
//   Debounced step counter. A raw, possibly bouncing request on pulse_in is
//   synchronized, debounced for DEBOUNCE_CYCLES consecutive high samples, and
//   then moves a 5-bit index up or down by one (mod 32). After each step a
//   hold-off window of HOLDOFF_CYCLES must elapse and the input must be seen
//   low before another press is accepted, so a held input steps exactly once.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous, active-high reset
//   pulse_in     in   raw asynchronous step request
//   dir          in   0 = increment, 1 = decrement (used only in STEP)
//   load         in   synchronous load strobe (overrides the FSM)
//   load_val     in   [4:0] value written to observ on load
//   observ       out  [4:0] registered index
//   step_strobe  out  one-cycle pulse, coincident with a stepped observ
//   busy         out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module pulse_stepper #(
    parameter int DEBOUNCE_CYCLES = 16,   // legal 1..64
    parameter int HOLDOFF_CYCLES  = 63    // legal 1..64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_in,
    input  logic       dir,
    input  logic       load,
    input  logic [4:0] load_val,
    output logic [4:0] observ,
    output logic       step_strobe,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_STEP,
        S_HOLDOFF
    } state_t;

    // Terminal counts; both fit the shared 6-bit counter for the full 1..64 range.
    localparam logic [5:0] DEB_LAST  = 6'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0] HOLD_LAST = 6'(HOLDOFF_CYCLES - 1);

    logic       r_sync1;
    logic       r_pulse_s;
    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_next;
    logic [4:0] r_observ;
    logic [4:0] w_observ_next;
    logic       r_strobe;
    logic       w_strobe_next;

    // Two-flop synchronizer. Load deliberately leaves it alone; only rst clears it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, making the chain a true two-stage shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_pulse_s <= 1'b0;
        end else begin
            r_sync1   <= pulse_in;
            r_pulse_s <= r_sync1;
        end
    end

    // Next-state / datapath logic. Load beats every FSM action, including STEP.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_observ_next = r_observ;
        w_strobe_next = 1'b0;

        if (load) begin
            w_state_next  = S_IDLE;
            w_cnt_next    = '0;
            w_observ_next = load_val;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pulse_s) begin
                        w_state_next = S_DEBOUNCE;
                        w_cnt_next   = '0;
                    end
                end
                S_DEBOUNCE: begin
                    if (!r_pulse_s) begin
                        w_state_next = S_IDLE;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_next = S_STEP;
                    end else begin
                        w_cnt_next = r_cnt + 6'd1;
                    end
                end
                S_STEP: begin
                    // 5-bit arithmetic wraps naturally: 31+1=0, 0-1=31.
                    w_observ_next = dir ? (r_observ - 5'd1) : (r_observ + 5'd1);
                    w_strobe_next = 1'b1;
                    w_state_next  = S_HOLDOFF;
                    w_cnt_next    = '0;
                end
                S_HOLDOFF: begin
                    // Counter saturates; a still-held input keeps us here so a
                    // single long press cannot produce a second step.
                    if (r_cnt == HOLD_LAST) begin
                        if (!r_pulse_s) begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 6'd1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_observ <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_observ <= w_observ_next;
            r_strobe <= w_strobe_next;
        end
    end

    assign observ      = r_observ;
    assign step_strobe = r_strobe;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_pulse_stepper.sv
// -----------------------------------------------------------------------------
// tb_pulse_stepper
//   Self-checking bench for pulse_stepper. A behavioural model, written in
//   terms of run lengths of synchronized-high samples and time since the last
//   step, predicts every step; predicted index values are queued and popped by
//   a monitor whenever the DUT raises step_strobe. The monitor also compares
//   observ, busy and step_strobe against the model every cycle.
// -----------------------------------------------------------------------------
module tb_pulse_stepper;

    localparam int D = 16;
    localparam int H = 63;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse_in = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_val = 5'd0;
    logic [4:0] observ;
    logic       step_strobe;
    logic       busy;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    pulse_stepper #(
        .DEBOUNCE_CYCLES (D),
        .HOLDOFF_CYCLES  (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .dir         (dir),
        .load        (load),
        .load_val    (load_val),
        .observ      (observ),
        .step_strobe (step_strobe),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model.
    //   armed   : a press may be recognised (idle or counting a run)
    //   run     : consecutive high synchronized samples seen while armed
    //   pending : D+1 high samples seen; the next edge performs the step
    //   since   : edges since the last step; re-arm once >= H with input low
    // ------------------------------------------------------------------
    logic [4:0] m_observ = 5'd0;
    bit         m_armed = 1'b1;
    int         m_run = 0;
    int         m_since = 0;
    bit         m_pending = 1'b0;
    bit         m_strobe = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_s1 = 1'b0;
    bit         m_s2 = 1'b0;
    bit         m_ps;
    logic [4:0] exp_q[$];

    always @(posedge clk) begin
        m_ps = m_s2;
        m_strobe = 1'b0;
        if (rst) begin
            m_observ = 5'd0; m_armed = 1'b1; m_run = 0; m_pending = 1'b0;
        end else if (load) begin
            m_observ = load_val; m_armed = 1'b1; m_run = 0; m_pending = 1'b0;
        end else if (m_pending) begin
            m_observ = dir ? m_observ - 5'd1 : m_observ + 5'd1;
            m_pending = 1'b0; m_armed = 1'b0; m_since = 0; m_run = 0;
            m_strobe = 1'b1;
            exp_q.push_back(m_observ);
        end else if (!m_armed) begin
            m_since++;
            if (m_since >= H && !m_ps) m_armed = 1'b1;
        end else if (m_ps) begin
            m_run++;
            if (m_run == D + 1) m_pending = 1'b1;
        end else begin
            m_run = 0;
        end
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            m_s2 = m_s1; m_s1 = pulse_in;
        end
        m_busy = !m_armed || (m_run > 0) || m_pending;
    end

    // Monitor: outputs only move on posedge, so the negedge is a stable sample point.
    always @(negedge clk) begin
        if (checking) begin
            check("observ_track", int'(observ), int'(m_observ));
            check("busy_track", int'(busy), int'(m_busy));
            check("strobe_track", int'(step_strobe), int'(m_strobe));
            if (step_strobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    check("strobe_value", int'(observ), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [4:0] v);
        load = 1'b1; load_val = v;
        tick(1);
        load = 1'b0;
    endtask

    // Wait (bounded) for a strobe; reports how many ticks it took.
    task automatic wait_strobe(input string name, input int max_ticks, output int took);
        int found = 0;
        took = 0;
        for (int k = 1; k <= max_ticks; k++) begin
            tick(1);
            if (step_strobe === 1'b1) begin
                found = 1; took = k;
                break;
            end
        end
        check(name, found, 1);
    endtask

    // Count strobes over a fixed window.
    task automatic count_strobes(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick(1);
            if (step_strobe === 1'b1) cnt++;
        end
    endtask

    initial begin
        int first;
        int n;
        int took;
        int idle_seen;

        // Reset and reset state.
        rst = 1'b1;
        tick(3);
        checking = 1'b1;
        check("rst_observ", int'(observ), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_strobe", int'(step_strobe), 0);

        // Held press: exactly one step, at edge 20 after reset release.
        rst = 1'b0; pulse_in = 1'b1; dir = 1'b0;
        first = 0; n = 0;
        for (int k = 1; k <= 200; k++) begin
            tick(1);
            if (step_strobe === 1'b1) begin
                n++;
                if (first == 0) first = k;
            end
        end
        check("hold_latency", first, 4 + D);
        check("hold_one_step", n, 1);
        check("hold_observ", int'(observ), 1);
        check("hold_busy_while_held", int'(busy), 1);
        pulse_in = 1'b0;
        idle_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (busy === 1'b0) begin idle_seen = 1; break; end
        end
        check("hold_busy_drops", idle_seen, 1);

        // Glitch shorter than the debounce window.
        pulse_in = 1'b1;
        count_strobes(10, n);
        pulse_in = 1'b0;
        begin
            int n2;
            count_strobes(10, n2);
            n += n2;
        end
        check("glitch_no_step", n, 0);
        check("glitch_observ", int'(observ), 1);
        check("glitch_idle", int'(busy), 0);

        // Wrap-around both directions.
        do_load(5'd31);
        dir = 1'b0; pulse_in = 1'b1; tick(25); pulse_in = 1'b0; tick(80);
        check("wrap_up", int'(observ), 0);
        do_load(5'd0);
        dir = 1'b1; pulse_in = 1'b1; tick(25); pulse_in = 1'b0; tick(80);
        check("wrap_down", int'(observ), 31);

        // Hold-off: a re-press inside the hold-off window that is still held
        // when the window ends is ignored; a fresh press afterwards steps.
        dir = 1'b0; pulse_in = 1'b1;
        wait_strobe("holdoff_first_step", 40, took);
        tick(5); pulse_in = 1'b0;
        tick(10); pulse_in = 1'b1;
        count_strobes(150, n);
        check("holdoff_held_no_step", n, 0);
        check("holdoff_observ_mid", int'(observ), 0);
        pulse_in = 1'b0; tick(5);
        pulse_in = 1'b1;
        wait_strobe("holdoff_second_step", 40, took);
        check("holdoff_second_latency", took, 4 + D);
        check("holdoff_observ_plus2", int'(observ), 1);
        pulse_in = 1'b0; tick(80);

        // Load during DEBOUNCE cancels the press.
        pulse_in = 1'b1; tick(10);
        check("ovr_in_debounce", int'(busy), 1);
        load = 1'b1; load_val = 5'd7; pulse_in = 1'b0;
        tick(1);
        load = 1'b0;
        count_strobes(20, n);
        check("ovr_load_no_step", n, 0);
        check("ovr_load_observ", int'(observ), 7);
        check("ovr_load_idle", int'(busy), 0);

        // Reset during HOLDOFF.
        pulse_in = 1'b1;
        wait_strobe("ovr_step_before_rst", 40, took);
        tick(10);
        check("ovr_in_holdoff", int'(busy), 1);
        rst = 1'b1; tick(1);
        rst = 1'b0; pulse_in = 1'b0;
        check("ovr_rst_observ", int'(observ), 0);
        check("ovr_rst_busy", int'(busy), 0);
        check("ovr_rst_strobe", int'(step_strobe), 0);
        count_strobes(20, n);
        check("ovr_rst_quiet", n, 0);

        // Randomized presses, bounces, loads and resets against the model.
        for (int i = 0; i < 60; i++) begin
            int r = int'($urandom_range(0, 15));
            if (r == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end else if (r < 3) begin
                do_load(5'($urandom_range(0, 31)));
            end else begin
                int hi = int'($urandom_range(1, 40));
                int bounce = int'($urandom_range(0, 6));
                for (int j = 0; j < hi; j++) begin
                    pulse_in = (j < bounce) ? 1'($urandom_range(0, 1)) : 1'b1;
                    dir = 1'($urandom_range(0, 1));
                    tick(1);
                end
                pulse_in = 1'b0;
                tick(int'($urandom_range(1, 90)));
            end
        end

        pulse_in = 1'b0;
        tick(100);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
